// File: rtl/temporizador_bcd.sv
// Two-digit BCD countdown timer for the irrigation phases: loads a duration,
// decrements it once every DIV_COUNT clocks and pulses 'fim' when it reaches 00.
module temporizador_bcd #(
    parameter int DIV_COUNT = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       carregar,
    input  logic [3:0] dezena_in,
    input  logic [3:0] unidade_in,
    input  logic       pausa,
    input  logic       cancelar,
    output logic [3:0] dezena_out,
    output logic [3:0] unidade_out,
    output logic       ativo,
    output logic       fim
);

    localparam int PW = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
    localparam logic [PW-1:0] ULTIMO = PW'(DIV_COUNT - 1);

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        CONTANDO = 2'b01,
        PAUSADO  = 2'b10,
        FIM      = 2'b11
    } estado_t;

    estado_t       estado;
    logic [PW-1:0] presc;
    logic [3:0]    dezena_sat;
    logic [3:0]    unidade_sat;
    logic          carga_zero;

    // Out-of-range BCD digits are saturated to 9 rather than rejected.
    function automatic logic [3:0] satura_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [7:0] decrementa_bcd(input logic [3:0] dz, input logic [3:0] un);
        if (un == 4'd0)
            return {dz - 4'd1, 4'd9};
        else
            return {dz, un - 4'd1};
    endfunction

    always_comb begin
        dezena_sat  = satura_bcd(dezena_in);
        unidade_sat = satura_bcd(unidade_in);
        carga_zero  = (dezena_sat == 4'd0) && (unidade_sat == 4'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado      <= OCIOSO;
            presc       <= '0;
            dezena_out  <= 4'd0;
            unidade_out <= 4'd0;
            ativo       <= 1'b0;
            fim         <= 1'b0;
        end else if (cancelar) begin
            estado      <= OCIOSO;
            presc       <= '0;
            dezena_out  <= 4'd0;
            unidade_out <= 4'd0;
            ativo       <= 1'b0;
            fim         <= 1'b0;
        end else if (carregar) begin
            presc       <= '0;
            dezena_out  <= dezena_sat;
            unidade_out <= unidade_sat;
            if (carga_zero) begin
                estado <= FIM;
                ativo  <= 1'b0;
                fim    <= 1'b1;
            end else begin
                estado <= CONTANDO;
                ativo  <= 1'b1;
                fim    <= 1'b0;
            end
        end else begin
            fim <= 1'b0;
            case (estado)
                // Leaving PAUSADO counts on the same edge, so a pause of N
                // cycles stretches the phase by exactly N cycles.
                CONTANDO, PAUSADO: begin
                    if (pausa) begin
                        estado <= PAUSADO;
                        ativo  <= 1'b1;
                    end else if (presc == ULTIMO) begin
                        presc <= '0;
                        if (dezena_out == 4'd0 && unidade_out == 4'd1) begin
                            estado      <= FIM;
                            dezena_out  <= 4'd0;
                            unidade_out <= 4'd0;
                            ativo       <= 1'b0;
                            fim         <= 1'b1;
                        end else begin
                            {dezena_out, unidade_out} <= decrementa_bcd(dezena_out, unidade_out);
                            estado <= CONTANDO;
                            ativo  <= 1'b1;
                        end
                    end else begin
                        presc  <= presc + PW'(1);
                        estado <= CONTANDO;
                        ativo  <= 1'b1;
                    end
                end
                FIM: begin
                    estado <= OCIOSO;
                    ativo  <= 1'b0;
                end
                default: begin
                    estado <= OCIOSO;
                    ativo  <= 1'b0;
                end
            endcase
        end
    end

endmodule
